ps2_key_buffer: RTL and testbench

Keyboard front end that produces the `pressed_key` byte and consumes the `clean_key_buffer` pulse of the memory subsystem's key port at address 0xFFFFFFFF. Receives PS/2 device-to-host frames, decodes Set 2 make codes, filters prefix and break codes, and queues keys in a small FIFO. The head of the FIFO is presented to the memory subsystem, and each CPU read of the key address pops one entry. Sits between the board PS/2 pins and the memory subsystem, clocked by the CPU clock.

---
 rtl/ps2_key_buffer.sv | 191 +++++++++++++++++++
 tb/tb_ps2_key_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_buffer.sv
// PS/2 Set 2 keyboard receiver with make-code filter and key FIFO for the CPU key port.
// Optional build macro PS2_PARITY_CHECK_EN: discard frames that fail the odd-parity check.
module ps2_key_buffer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       CLK_CPU,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clean_key_buffer,
  output logic [7:0] pressed_key,
  output logic       key_valid,
  output logic       key_overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic             fall;
  logic             bit_in;

  state_t           state;
  state_t           state_next;
  logic             cnt_clr;
  logic             shift_en;
  logic             frame_ok;
  logic             timed_out;
  logic             parity_good;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [TO_W-1:0]  to_cnt;
  logic             frame_done;

  logic             brk;
  logic             brk_next;
  logic             push;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             clean_prev;
  logic             pop;
  logic             full;
  logic             wr;

  // Pin synchronisers; idle-high reset avoids a false edge after reset release
  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];
  assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) par_bit <= 1'b0;
    else if (state == PARITY && fall) par_bit <= bit_in;
  end

  assign parity_good = ^{shift, par_bit};
`else
  assign parity_good = 1'b1;
`endif

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Frame sequencing; a stalled partial frame falls back to IDLE on timeout
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    frame_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !bit_in) begin
          cnt_clr    = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall) state_next = STOP;
      end
      STOP: begin
        if (fall) begin
          frame_ok   = bit_in & parity_good;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state != IDLE && !fall && timed_out) state_next = IDLE;
  end

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      to_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      if (cnt_clr) bit_cnt <= 3'd0;
      if (shift_en) begin
        shift   <= {bit_in, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == IDLE || fall || timed_out) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + TO_W'(1);
      frame_done <= frame_ok;
    end
  end

  // Make-code filter: drop prefixes, the byte after a break code, and 0x00
  always_comb begin
    brk_next = brk;
    push     = 1'b0;
    if (frame_done) begin
      if (shift == 8'hE0) begin
        brk_next = brk;
      end else if (shift == 8'hF0) begin
        brk_next = 1'b1;
      end else if (brk) begin
        brk_next = 1'b0;
      end else if (shift != 8'h00) begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) brk <= 1'b0;
    else         brk <= brk_next;
  end

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign pop  = clean_key_buffer & ~clean_prev & (count != '0);
  assign wr   = push & (~full | pop);

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      clean_prev   <= 1'b0;
      key_overflow <= 1'b0;
    end else begin
      clean_prev <= clean_key_buffer;
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (wr && !pop)      count <= count + CNT_W'(1);
      else if (!wr && pop) count <= count - CNT_W'(1);
      if (push && full && !pop) key_overflow <= 1'b1;
      else if (pop)             key_overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK_CPU) begin
    if (wr) mem[wr_ptr] <= shift;
  end

  assign key_valid   = (count != '0);
  assign pressed_key = key_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Self-checking bench for ps2_key_buffer: queue-based key model plus directed PS/2 frames.
module tb_ps2_key_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 300;
  localparam int unsigned HALF  = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       clean_key_buffer = 1'b0;
  logic [7:0] pressed_key;
  logic       key_valid;
  logic       key_overflow;

  always #5 clk = ~clk;

  ps2_key_buffer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_CPU(clk),
    .resetn(resetn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .clean_key_buffer(clean_key_buffer),
    .pressed_key(pressed_key),
    .key_valid(key_valid),
    .key_overflow(key_overflow)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  bit         check_en = 1'b0;
  logic [7:0] q[$];
  bit         m_brk = 1'b0;
  bit         m_ovf = 1'b0;
  logic [7:0] exp_key;
  int         last_lat;
  logic [7:0] last_lat_key;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Outputs must equal the model's queue head, emptiness and overflow flag
  always @(negedge clk) begin
    if (check_en) begin
      exp_key = (q.size() != 0) ? q[0] : 8'h00;
      check("model_outputs", 32'({pressed_key, key_valid, key_overflow}),
            32'({exp_key, q.size() != 0, m_ovf}));
    end
  end

  task automatic model_frame(input logic [7:0] b, input bit par_ok);
`ifdef PS2_PARITY_CHECK_EN
    if (!par_ok) return;
`endif
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin m_brk = 1'b1; return; end
    if (m_brk) begin m_brk = 1'b0; return; end
    if (b == 8'h00) return;
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic model_pop();
    if (q.size() != 0) begin
      void'(q.pop_front());
      m_ovf = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par_ok);
    logic par;
    par = par_ok ? ~^b : ^b;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Device drives data while clock is high; host samples on the falling edge
  task automatic send_bits(input logic [10:0] bits, input int n);
    last_lat = -1;
    last_lat_key = 8'h00;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      if (i == 10) check_en = 1'b0;
      ps2_clk = 1'b0;
      for (int j = 1; j <= int'(HALF); j++) begin
        @(posedge clk);
        #1;
        if (i == 10 && last_lat < 0 && key_valid) begin
          last_lat = j;
          last_lat_key = pressed_key;
        end
      end
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok);
    send_bits(frame_bits(b, par_ok), 11);
    model_frame(b, par_ok);
    check_en = 1'b1;
  endtask

  task automatic pop_pulse(input int hold);
    clean_key_buffer = 1'b1;
    @(posedge clk);
    model_pop();
    repeat (hold - 1) @(posedge clk);
    #1;
    clean_key_buffer = 1'b0;
    wait_cyc(2);
  endtask

  initial begin
    logic [7:0] pop_exp [5];
    pop_exp[0] = 8'h15; pop_exp[1] = 8'h1D; pop_exp[2] = 8'h24;
    pop_exp[3] = 8'h2D; pop_exp[4] = 8'h00;

    wait_cyc(3);
    check("reset_key", 32'(pressed_key), 32'h00);
    check("reset_valid", 32'(key_valid), 32'h0);
    check("reset_ovf", 32'(key_overflow), 32'h0);
    resetn = 1'b1;
    wait_cyc(2);
    check_en = 1'b1;

    // Single key: latency from the stop-bit pin edge, then a one-cycle pop
    send_frame(8'h1C, 1'b1);
    n_checks++;
    if (last_lat >= 4 && last_lat <= 5) n_pass++;
    else $display("FAIL push_latency: got %0d cycles, expected 4..5", last_lat);
    check("latency_key", 32'(last_lat_key), 32'h1C);
    check("key_1c", 32'(pressed_key), 32'h1C);
    pop_pulse(1);
    check("empty_after_pop", 32'({pressed_key, key_valid}), 32'h000);

    // Break and extended prefixes
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b1);
    check("break_dropped", 32'(key_valid), 32'h0);
    send_frame(8'hE0, 1'b1);
    send_frame(8'h75, 1'b1);
    check("ext_key", 32'(pressed_key), 32'h75);
    pop_pulse(1);
    check("ext_popped", 32'(key_valid), 32'h0);

    // Overflow with five keys into four slots
    send_frame(8'h15, 1'b1);
    send_frame(8'h1D, 1'b1);
    send_frame(8'h24, 1'b1);
    send_frame(8'h2D, 1'b1);
    send_frame(8'h2C, 1'b1);
    check("ovf_set", 32'(key_overflow), 32'h1);
    for (int k = 0; k < 5; k++) begin
      check("pop_order", 32'(pressed_key), 32'(pop_exp[k]));
      pop_pulse(1);
      if (k == 0) check("ovf_cleared", 32'(key_overflow), 32'h0);
    end
    check("drained", 32'(key_valid), 32'h0);

    // Long request pops exactly one key
    send_frame(8'h1C, 1'b1);
    send_frame(8'h32, 1'b1);
    pop_pulse(10);
    check("held_pop_key", 32'(pressed_key), 32'h32);
    check("held_pop_valid", 32'(key_valid), 32'h1);
    pop_pulse(1);

    // Bad parity
    send_frame(8'h1C, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("bad_parity_dropped", 32'(key_valid), 32'h0);
`else
    check("bad_parity_kept", 32'(pressed_key), 32'h1C);
`endif
    pop_pulse(1);

    // Partial frame abandoned by timeout
    send_bits(frame_bits(8'h32, 1'b1), 4);
    wait_cyc(TO + 5);
    send_frame(8'h32, 1'b1);
    check("after_timeout", 32'(pressed_key), 32'h32);
    pop_pulse(1);

    // Reset mid-frame with a key queued
    send_frame(8'h15, 1'b1);
    send_bits(frame_bits(8'h32, 1'b1), 4);
    check_en = 1'b0;
    resetn = 1'b0;
    wait_cyc(2);
    check("rst_mid_outputs", 32'({pressed_key, key_valid, key_overflow}), 32'h000);
    resetn = 1'b1;
    q.delete();
    m_brk = 1'b0;
    m_ovf = 1'b0;
    check_en = 1'b1;
    wait_cyc(TO + 5);
    check("rst_mid_empty", 32'(key_valid), 32'h0);
    send_frame(8'h2C, 1'b1);
    check("after_reset_key", 32'(pressed_key), 32'h2C);
    pop_pulse(1);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
